seq_fsm_hardened: RTL and testbench
===================================

Name: seq_fsm_hardened

Overview:
- Parametrised, fault-hardened successor of the count-then-finish sequencer.
- After start, runs ROUNDS counting rounds of CNT_MAX+1 cycles each, pulses done, then holds a final data word.
- Sparse state encoding plus a shadowed counter pair detect illegal states and counter corruption, raising a sticky alert.
- Sits beside the fault-injection example targets as the hardened reference design for campaign comparison.

Parameters:
- DATA_W, 8, width of data_o.
- CNT_W, 4, width of the cycle counter.
- CNT_MAX, 12, terminal count per round; must be < 2**CNT_W.
- ROUNDS, 2, number of counting rounds; must be >= 1. RND_W = $clog2(ROUNDS+1) is derived.
- FINAL_DATA, 8'h5a (DATA_W wide), word presented on data_o in FINAL.
- IDLE_DATA, 8'hac (DATA_W wide), word presented on data_o in IDLE.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start_i  input  1  start request, sampled in IDLE only.
- clear_i  input  1  return FINAL to IDLE; ignored in all other states.
- abort_i  input  1  return COUNT/ROUND to IDLE.
- data_o  output  DATA_W  output data word, combinational from state.
- done_o  output  1  one-cycle completion pulse, high in DONE.
- busy_o  output  1  high in COUNT or ROUND.
- round_o  output  RND_W  number of completed rounds.
- alert_o  output  1  high in ERROR, sticky.

Behaviour:
- State register is 5 bits, with pairwise Hamming distance >= 2 between codes:
  - IDLE 10011, COUNT 01101, ROUND 11110, DONE 00110, FINAL 01010, ERROR 11001.
  - Any other code is illegal and the next state is ERROR.
- Reset (rst=0 at an edge) has priority over everything, including ERROR and mid-count. Reset values:
  - state=IDLE, cnt=0, cnt_shadow=all-ones, rnd=0.
  - data_o=IDLE_DATA, done_o=0, busy_o=0, round_o=0, alert_o=0.
- IDLE: data_o=IDLE_DATA. start_i=1 goes to COUNT with cnt=0 and rnd=0.
- COUNT:
  - cnt increments by 1 each cycle.
  - When cnt==CNT_MAX, go to ROUND (CNT_MAX+1 cycles in COUNT per round).
  - abort_i=1 goes to IDLE and clears cnt and rnd; abort has priority over the terminal count.
- ROUND:
  - cnt cleared, rnd incremented.
  - If rnd+1==ROUNDS go to DONE, else go to COUNT.
  - abort_i=1 goes to IDLE.
- DONE: done_o=1 for exactly one cycle, then go to FINAL.
- FINAL:
  - data_o=FINAL_DATA; the state holds.
  - clear_i=1 goes to IDLE and clears rnd.
  - start_i is ignored.
- ERROR: alert_o=1, data_o=0, busy_o=0, done_o=0. The state holds until reset; start/clear/abort are ignored.
- data_o=0 in COUNT, ROUND and DONE.
- Shadow counter:
  - cnt_shadow always receives ~(next cnt).
  - At every edge outside reset, if cnt != ~cnt_shadow, the next state is ERROR. This overrides normal transitions.
- Counter arithmetic is modulo 2**CNT_W. Wrap-around never occurs in legal operation; a wrap can only result from a fault and is caught by the ERROR path.
- Latency: done_o asserts ROUNDS*(CNT_MAX+2)+1 cycles after the edge that samples start_i (29 with defaults). FINAL follows one cycle later.
- Simultaneous events:
  - abort_i with terminal count: abort wins.
  - Shadow mismatch with any input: ERROR wins.
  - clear_i and start_i in FINAL: clear wins, and start is not re-sampled until IDLE.

Test Plan:
- Reset (rst=0 for 2 cycles), then start_i=1 for 1 cycle with defaults -> busy_o=1 next cycle; done_o=1 exactly 29 cycles after start; data_o=8'h5a from cycle 30 onward; round_o=2.
- Assert abort_i when cnt==7 in round 0 -> IDLE next cycle; data_o=8'hac; round_o=0; a later start runs the full 29-cycle sequence.
- In FINAL, pulse clear_i -> IDLE; round_o=0; data_o=8'hac; start_i is ignored during FINAL.
- Force the state register to 5'b00000 for one cycle -> alert_o=1 from the next cycle; data_o=0; alert_o stays high through start_i/clear_i until rst=0.
- Flip cnt bit 2 during COUNT (shadow left intact) -> ERROR on the next edge; alert_o=1; done_o never asserts.
- Parameter run with CNT_MAX=3, ROUNDS=4, DATA_W=16 -> done_o exactly 21 cycles after start; round_o=4; data_o=FINAL_DATA.

Source files
------------

// File: rtl/seq_fsm_hardened.sv
// -----------------------------------------------------------------------------
// seq_fsm_hardened
//
// Fault-hardened count-then-finish sequencer. After a start request it runs
// ROUNDS counting rounds of CNT_MAX+1 cycles each, pulses done for one cycle,
// then parks in FINAL presenting FINAL_DATA until cleared.
//
// The hardening works in two ways:
//   * The state codes are sparse, and any two codes differ in at least two
//     bits. A single upset therefore always lands on an illegal code, and an
//     illegal code is steered to ERROR.
//   * The cycle counter has a shadow copy that always holds the bitwise
//     complement. Any disagreement between the two sends the FSM to ERROR.
// ERROR is backed by a separate sticky alert flag. Even if an upset knocks
// the state register out of ERROR, the flag pulls it straight back and
// keeps the outputs in their safe values until reset.
//
// Ports:
//   clk      in   1       clock, rising edge
//   rst      in   1       synchronous reset, active low
//   start_i  in   1       start request (sampled in IDLE only)
//   clear_i  in   1       FINAL -> IDLE (ignored elsewhere)
//   abort_i  in   1       COUNT/ROUND -> IDLE
//   data_o   out  DATA_W  IDLE_DATA in IDLE, FINAL_DATA in FINAL, else 0
//   done_o   out  1       high for the single DONE cycle
//   busy_o   out  1       high in COUNT or ROUND
//   round_o  out  RND_W   number of completed rounds
//   alert_o  out  1       sticky fault indication (ERROR)
// -----------------------------------------------------------------------------
module seq_fsm_hardened #(
    parameter int                DATA_W     = 8,
    parameter int                CNT_W      = 4,
    parameter int                CNT_MAX    = 12,
    parameter int                ROUNDS     = 2,
    parameter logic [DATA_W-1:0] FINAL_DATA = DATA_W'(8'h5a),
    parameter logic [DATA_W-1:0] IDLE_DATA  = DATA_W'(8'hac),
    localparam int               RND_W      = $clog2(ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              abort_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o,
    output logic              busy_o,
    output logic [RND_W-1:0]  round_o,
    output logic              alert_o
);

    // Sparse state codes: every pair is at least Hamming distance 2 apart.
    localparam logic [4:0] ST_IDLE  = 5'b10011;
    localparam logic [4:0] ST_COUNT = 5'b01101;
    localparam logic [4:0] ST_ROUND = 5'b11110;
    localparam logic [4:0] ST_DONE  = 5'b00110;
    localparam logic [4:0] ST_FINAL = 5'b01010;
    localparam logic [4:0] ST_ERROR = 5'b11001;

    localparam logic [CNT_W-1:0] CNT_TERM   = CNT_W'(CNT_MAX);
    localparam logic [RND_W-1:0] RND_LAST   = RND_W'(ROUNDS);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [RND_W-1:0] RND_ZERO   = '0;

    logic [4:0]       state_reg;
    logic [4:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_shadow_reg;
    logic [CNT_W-1:0] cnt_shadow_next;
    logic [RND_W-1:0] rnd_reg;
    logic [RND_W-1:0] rnd_next;
    logic [RND_W-1:0] rnd_inc;
    logic             alert_reg;
    logic             alert_next;

    // Per-bit agreement between counter and shadow. The pair is healthy only
    // when every bit of the shadow is the complement of the counter bit.
    logic [CNT_W-1:0] cnt_pair_ok;
    logic             counter_fault;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_shadow
            assign cnt_shadow_next[gi] = ~cnt_next[gi];
            assign cnt_pair_ok[gi]     = cnt_reg[gi] ^ cnt_shadow_reg[gi];
        end
    endgenerate

    assign counter_fault = ~(&cnt_pair_ok);
    assign rnd_inc       = rnd_reg + RND_W'(1);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rnd_next   = rnd_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_COUNT;
                    cnt_next   = CNT_ZERO;
                    rnd_next   = RND_ZERO;
                end
            end

            ST_COUNT: begin
                if (abort_i) begin
                    // Abort beats the terminal count.
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                    rnd_next   = RND_ZERO;
                end else if (cnt_reg == CNT_TERM) begin
                    // Clear here rather than increment so that CNT_MAX at
                    // the top of the counter range never wraps in legal use.
                    state_next = ST_ROUND;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_ROUND: begin
                if (abort_i) begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                    rnd_next   = RND_ZERO;
                end else begin
                    cnt_next   = CNT_ZERO;
                    rnd_next   = rnd_inc;
                    state_next = (rnd_inc == RND_LAST) ? ST_DONE : ST_COUNT;
                end
            end

            ST_DONE: begin
                state_next = ST_FINAL;
            end

            ST_FINAL: begin
                // start_i is deliberately not looked at here; clear wins.
                if (clear_i) begin
                    state_next = ST_IDLE;
                    rnd_next   = RND_ZERO;
                end
            end

            ST_ERROR: begin
                state_next = ST_ERROR;
            end

            default: begin
                // Any code outside the legal set is an upset.
                state_next = ST_ERROR;
            end
        endcase

        // Counter corruption, or an earlier fault already latched, overrides
        // every normal transition.
        if (counter_fault || alert_reg) begin
            state_next = ST_ERROR;
        end

        // Once heading to ERROR the counter is frozen; the shadow still
        // follows the complement of the frozen value.
        if (state_next == ST_ERROR) begin
            cnt_next = cnt_reg;
            rnd_next = rnd_reg;
        end
    end

    assign alert_next = alert_reg | (state_next == ST_ERROR);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            cnt_shadow_reg <= '1;
            rnd_reg        <= '0;
            alert_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            cnt_shadow_reg <= cnt_shadow_next;
            rnd_reg        <= rnd_next;
            alert_reg      <= alert_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the state. A latched alert forces every other
    // output to its safe value, whatever the state register happens to hold.
    // -------------------------------------------------------------------------
    logic in_error;

    assign in_error = (state_reg == ST_ERROR) | alert_reg;
    assign alert_o  = in_error;
    assign round_o  = rnd_reg;
    assign done_o   = ~in_error & (state_reg == ST_DONE);
    assign busy_o   = ~in_error & ((state_reg == ST_COUNT) | (state_reg == ST_ROUND));

    always_comb begin
        data_o = '0;
        if (!in_error) begin
            if (state_reg == ST_IDLE) begin
                data_o = IDLE_DATA;
            end else if (state_reg == ST_FINAL) begin
                data_o = FINAL_DATA;
            end
        end
    end

endmodule

// File: tb/tb_seq_fsm_hardened.sv
// -----------------------------------------------------------------------------
// Testbench for seq_fsm_hardened.
// dut  : default parameters (CNT_MAX=12, ROUNDS=2, DATA_W=8)
// dut2 : CNT_MAX=3, ROUNDS=4, DATA_W=16
// Expected output values are pushed to a scoreboard queue as stimulus is
// applied, then popped and compared one clock later, #1 after the edge.
// Latency is counted in rising edges, with the edge that samples start_i
// counted as edge 1.
// -----------------------------------------------------------------------------
module tb_seq_fsm_hardened;

    localparam int          LAT1   = 2 * (12 + 2) + 1;  // 29
    localparam int          LAT2   = 4 * (3 + 2) + 1;   // 21
    localparam logic [15:0] FD2    = 16'hc3a5;
    localparam logic [15:0] ID2    = 16'h0f1e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, clear, abort;
    logic [7:0] data;
    logic       done, busy, alert;
    logic [1:0] rnd;

    logic        start2, clear2, abort2;
    logic [15:0] data2;
    logic        done2, busy2, alert2;
    logic [2:0]  rnd2;

    seq_fsm_hardened dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .clear_i (clear),
        .abort_i (abort),
        .data_o  (data),
        .done_o  (done),
        .busy_o  (busy),
        .round_o (rnd),
        .alert_o (alert)
    );

    seq_fsm_hardened #(
        .DATA_W     (16),
        .CNT_W      (4),
        .CNT_MAX    (3),
        .ROUNDS     (4),
        .FINAL_DATA (FD2),
        .IDLE_DATA  (ID2)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start2),
        .clear_i (clear2),
        .abort_i (abort2),
        .data_o  (data2),
        .done_o  (done2),
        .busy_o  (busy2),
        .round_o (rnd2),
        .alert_o (alert2)
    );

    // Output selectors used by scoreboard entries.
    localparam int K_DATA  = 0;
    localparam int K_DONE  = 1;
    localparam int K_BUSY  = 2;
    localparam int K_RND   = 3;
    localparam int K_ALERT = 4;
    localparam int K_DATA2 = 5;
    localparam int K_DONE2 = 6;
    localparam int K_RND2  = 7;
    localparam int K_BUSY2 = 8;
    localparam int K_ALRT2 = 9;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_DATA:  return {24'b0, data};
            K_DONE:  return {31'b0, done};
            K_BUSY:  return {31'b0, busy};
            K_RND:   return {30'b0, rnd};
            K_ALERT: return {31'b0, alert};
            K_DATA2: return {16'b0, data2};
            K_DONE2: return {31'b0, done2};
            K_RND2:  return {29'b0, rnd2};
            K_BUSY2: return {31'b0, busy2};
            K_ALRT2: return {31'b0, alert2};
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pending();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full default-parameter run from IDLE to FINAL, with latency check.
    task automatic run_full(input string tag);
        int n;
        bit gap;
        start = 1'b1;
        tick();
        start = 1'b0;
        n   = 1;
        gap = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) gap = 1'b1;
            tick();
            n++;
        end
        cmp({tag, "_latency"}, n, LAT1);
        cmp({tag, "_busy_held"}, {31'b0, gap}, 0);
        push({tag, "_done_data"}, K_DATA, 32'h0);
        push({tag, "_done_rnd"},  K_RND,  32'd2);
        check_pending();
        tick();
        push({tag, "_done_pulse"}, K_DONE, 32'd0);
        push({tag, "_final_data"}, K_DATA, 32'h5a);
        push({tag, "_final_rnd"},  K_RND,  32'd2);
        push({tag, "_final_busy"}, K_BUSY, 32'd0);
        check_pending();
    endtask

    task automatic clear_to_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [3:0] cnt_tmp;
        bit         seen_done;
        int         n;

        rst    = 1'b0;
        start  = 1'b0; clear  = 1'b0; abort  = 1'b0;
        start2 = 1'b0; clear2 = 1'b0; abort2 = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        push("rst_data",   K_DATA,  32'hac);
        push("rst_done",   K_DONE,  32'd0);
        push("rst_busy",   K_BUSY,  32'd0);
        push("rst_rnd",    K_RND,   32'd0);
        push("rst_alert",  K_ALERT, 32'd0);
        push("rst_data2",  K_DATA2, {16'b0, ID2});
        check_pending();
        rst = 1'b1;
        tick();

        // ---------------- nominal run ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        push("start_busy", K_BUSY, 32'd1);
        push("start_data", K_DATA, 32'h0);
        check_pending();
        // Abort immediately to keep run_full self-contained from IDLE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_full("run1");
        tick();
        push("final_hold", K_DATA, 32'h5a);
        check_pending();

        // ---------------- FINAL: start ignored, clear wins ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        push("final_start_ign_data", K_DATA, 32'h5a);
        push("final_start_ign_busy", K_BUSY, 32'd0);
        push("final_start_ign_rnd",  K_RND,  32'd2);
        check_pending();
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        push("clear_data", K_DATA, 32'hac);
        push("clear_rnd",  K_RND,  32'd0);
        push("clear_busy", K_BUSY, 32'd0);
        check_pending();
        tick();
        push("clear_no_restart", K_BUSY, 32'd0);
        check_pending();

        // ---------------- abort at cnt==7 ----------------
        start = 1'b1;
        tick();                       // cnt = 0
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();  // cnt = 7
        abort = 1'b1;
        tick();
        abort = 1'b0;
        push("abort7_data", K_DATA, 32'hac);
        push("abort7_rnd",  K_RND,  32'd0);
        push("abort7_busy", K_BUSY, 32'd0);
        check_pending();
        run_full("run2");
        clear_to_idle();

        // ---------------- abort together with terminal count ----------------
        start = 1'b1;
        tick();                       // cnt = 0
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick(); // cnt = 12 (terminal)
        abort = 1'b1;
        tick();
        abort = 1'b0;
        push("abort_tc_busy", K_BUSY, 32'd0);
        push("abort_tc_data", K_DATA, 32'hac);
        push("abort_tc_rnd",  K_RND,  32'd0);
        check_pending();

        // ---------------- illegal state code ----------------
        dut.state_reg = 5'b00000;
        tick();
        push("illegal_alert", K_ALERT, 32'd1);
        push("illegal_data",  K_DATA,  32'h0);
        push("illegal_busy",  K_BUSY,  32'd0);
        push("illegal_done",  K_DONE,  32'd0);
        check_pending();
        start = 1'b1; clear = 1'b1; abort = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0; clear = 1'b0; abort = 1'b0;
        push("err_sticky_alert", K_ALERT, 32'd1);
        push("err_sticky_data",  K_DATA,  32'h0);
        push("err_sticky_busy",  K_BUSY,  32'd0);
        check_pending();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push("err_rst_alert", K_ALERT, 32'd0);
        push("err_rst_data",  K_DATA,  32'hac);
        check_pending();

        // ---------------- counter corruption ----------------
        start = 1'b1;
        tick();                       // cnt = 0
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();  // cnt = 3
        cnt_tmp       = dut.cnt_reg;
        cnt_tmp[2]    = ~cnt_tmp[2];
        dut.cnt_reg   = cnt_tmp;
        tick();
        push("cntflip_alert", K_ALERT, 32'd1);
        push("cntflip_busy",  K_BUSY,  32'd0);
        push("cntflip_data",  K_DATA,  32'h0);
        check_pending();
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) seen_done = 1'b1;
            tick();
        end
        cmp("cntflip_no_done", {31'b0, seen_done}, 0);
        push("cntflip_alert_held", K_ALERT, 32'd1);
        check_pending();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push("cntflip_rst_alert", K_ALERT, 32'd0);
        check_pending();

        // ---------------- parameterised instance ----------------
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1;
        while (done2 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        cmp("p2_latency", n, LAT2);
        push("p2_done_rnd", K_RND2, 32'd4);
        check_pending();
        tick();
        push("p2_final_data", K_DATA2, {16'b0, FD2});
        push("p2_final_rnd",  K_RND2,  32'd4);
        push("p2_done_pulse", K_DONE2, 32'd0);
        push("p2_alert",      K_ALRT2, 32'd0);
        push("p2_busy",       K_BUSY2, 32'd0);
        check_pending();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
